// File: rtl/lookupflow_learn_pkg.sv
// ---------------------------------------------------------------------------
// lookupflow_learn_pkg
//   Shared constants and types for the learning L2 forwarding lookup:
//   MAC width, broadcast address, tuple field offsets and the lookup FSM
//   state encoding.
// ---------------------------------------------------------------------------
package lookupflow_learn_pkg;

  localparam int MAC_W   = 48;
  localparam int TUPLE_W = 2 * MAC_W;

  // Tuple layout: {dst MAC, src MAC}
  localparam int DST_LSB = MAC_W;
  localparam int SRC_LSB = 0;

  // I/G bit of the source MAC (first octet LSB); set means group address.
  localparam int SRC_MC_BIT = 40;

  localparam logic [MAC_W-1:0] BCAST_MAC = 48'hffff_ffff_ffff;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic is_group_mac(input logic [MAC_W-1:0] mac);
    return mac[SRC_MC_BIT];
  endfunction

endpackage

// File: rtl/lookupflow_learn_cam.sv
// ---------------------------------------------------------------------------
// lookupflow_learn_cam
//   DEPTH-entry fully associative MAC table: {valid, mac, port, age} per entry.
//   Ports:
//     clk_i, srst_i      clock, synchronous active-high reset
//     flush_i            invalidate all entries, victim pointer back to 0
//     tick_i             age decrement strobe
//     dst_mac_i/src_mac_i  keys compared against all valid entries (combinational)
//     dst_hit_o          any valid entry matches dst
//     dst_port_o         port mask of the lowest-index dst match
//     src_hit_o          one-hot (by construction) src match vector
//     learn_i            write one entry this cycle
//     learn_hit_i        src match vector registered at compare time
//     learn_mac_i/learn_port_i  data written by a learn
// ---------------------------------------------------------------------------
module lookupflow_learn_cam
  import lookupflow_learn_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int DEPTH = 16,
  parameter int AGE_W = 4
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             flush_i,
  input  logic             tick_i,
  input  logic [MAC_W-1:0] dst_mac_i,
  input  logic [MAC_W-1:0] src_mac_i,
  output logic             dst_hit_o,
  output logic [NPORT-1:0] dst_port_o,
  output logic [DEPTH-1:0] src_hit_o,
  input  logic             learn_i,
  input  logic [DEPTH-1:0] learn_hit_i,
  input  logic [MAC_W-1:0] learn_mac_i,
  input  logic [NPORT-1:0] learn_port_i
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [DEPTH-1:0] valid_q;
  logic [MAC_W-1:0] mac_q  [DEPTH];
  logic [NPORT-1:0] port_q [DEPTH];
  logic [AGE_W-1:0] age_q  [DEPTH];
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [DEPTH-1:0] dst_vec;
  logic [DEPTH-1:0] wr_sel;
  logic             evict;

  function automatic logic [DEPTH-1:0] lowest_one(input logic [DEPTH-1:0] v);
    return v & (~v + DEPTH'(1));
  endfunction

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign dst_vec[gi]   = valid_q[gi] && (mac_q[gi] == dst_mac_i);
      assign src_hit_o[gi] = valid_q[gi] && (mac_q[gi] == src_mac_i);
    end
  endgenerate

  assign dst_hit_o = |dst_vec;

  // Lowest index wins should a duplicate ever exist.
  always_comb begin
    dst_port_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (dst_vec[i]) dst_port_o = port_q[i];
    end
  end

  // Learn target: refresh existing entry, else first free slot, else victim.
  always_comb begin
    wr_sel = '0;
    evict  = 1'b0;
    ptr_d  = ptr_q;
    if (|learn_hit_i) begin
      wr_sel = lowest_one(learn_hit_i);
    end else if (!(&valid_q)) begin
      wr_sel = lowest_one(~valid_q);
    end else begin
      wr_sel = DEPTH'(1) << ptr_q;
      evict  = 1'b1;
      ptr_d  = (ptr_q == IDX_W'(DEPTH - 1)) ? '0 : ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mac_q[i]  <= '0;
        port_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      if (learn_i && evict) ptr_q <= ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (learn_i && wr_sel[i]) begin
          // A freshly written entry is exempt from a coincident tick.
          valid_q[i] <= 1'b1;
          mac_q[i]   <= learn_mac_i;
          port_q[i]  <= learn_port_i;
          age_q[i]   <= AGE_MAX;
        end else if (tick_i && valid_q[i]) begin
          age_q[i] <= age_q[i] - AGE_W'(1);
          if (age_q[i] == AGE_W'(1)) valid_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/lookupflow_learn.sv
// ---------------------------------------------------------------------------
// lookupflow_learn
//   Learning L2 forwarding lookup. Each accepted request learns src MAC ->
//   in_port and looks up dst MAC, answering with an egress port mask two
//   cycles later (unicast on hit, flood on miss/broadcast).
//   Ports:
//     sys_clk, sys_rst   clock, synchronous active-high reset
//     req                lookup request, accepted only when idle
//     tuple              {dst MAC, src MAC}, sampled on acceptance
//     in_port            one-hot ingress port, sampled on acceptance
//     flush              invalidate the whole table
//     ack                one-cycle response strobe
//     fwd_port           egress mask, held until the next ack
//     hit                dst found in table
// ---------------------------------------------------------------------------
module lookupflow_learn
  import lookupflow_learn_pkg::*;
#(
  parameter int NPORT    = 4,
  parameter int DEPTH    = 16,
  parameter int AGE_W    = 4,
  parameter int AGE_TICK = 1024
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               req,
  input  logic [TUPLE_W-1:0] tuple,
  input  logic [NPORT-1:0]   in_port,
  input  logic               flush,
  output logic               ack,
  output logic [NPORT-1:0]   fwd_port,
  output logic               hit
);

  localparam int PRE_W = (AGE_TICK > 1) ? $clog2(AGE_TICK) : 1;

  state_e           state_q;
  logic [MAC_W-1:0] dst_q, src_q;
  logic [NPORT-1:0] in_port_q;
  logic [DEPTH-1:0] src_hit_q;
  logic             flushed_q;
  logic             ack_q, hit_q;
  logic [NPORT-1:0] fwd_q;
  logic [PRE_W-1:0] pre_q, pre_d;

  logic             tick;
  logic             learn;
  logic             cam_dst_hit;
  logic [NPORT-1:0] cam_dst_port;
  logic [DEPTH-1:0] cam_src_hit;

  // Age prescaler: tick on the wrap from AGE_TICK-1 to 0.
  assign tick  = (pre_q == PRE_W'(AGE_TICK - 1));
  assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) pre_q <= '0;
    else         pre_q <= pre_d;
  end

  // A flush seen during MATCH already wiped the table; learning now would
  // leave a stale entry behind, so the learn is dropped.
  assign learn = (state_q == ST_RESP) && !is_group_mac(src_q) && !flushed_q;

  lookupflow_learn_cam #(
    .NPORT (NPORT),
    .DEPTH (DEPTH),
    .AGE_W (AGE_W)
  ) u_cam (
    .clk_i        (sys_clk),
    .srst_i       (sys_rst),
    .flush_i      (flush),
    .tick_i       (tick),
    .dst_mac_i    (dst_q),
    .src_mac_i    (src_q),
    .dst_hit_o    (cam_dst_hit),
    .dst_port_o   (cam_dst_port),
    .src_hit_o    (cam_src_hit),
    .learn_i      (learn),
    .learn_hit_i  (src_hit_q),
    .learn_mac_i  (src_q),
    .learn_port_i (in_port_q)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      dst_q     <= '0;
      src_q     <= '0;
      in_port_q <= '0;
      src_hit_q <= '0;
      flushed_q <= 1'b0;
      ack_q     <= 1'b0;
      hit_q     <= 1'b0;
      fwd_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            dst_q     <= tuple[DST_LSB +: MAC_W];
            src_q     <= tuple[SRC_LSB +: MAC_W];
            in_port_q <= in_port;
            state_q   <= ST_MATCH;
          end
        end
        ST_MATCH: begin
          // Response is frozen from the table as seen in this cycle.
          src_hit_q <= cam_src_hit;
          flushed_q <= flush;
          ack_q     <= 1'b1;
          if (dst_q == BCAST_MAC || !cam_dst_hit) begin
            fwd_q <= ~in_port_q;
            hit_q <= 1'b0;
          end else begin
            fwd_q <= cam_dst_port & ~in_port_q;
            hit_q <= 1'b1;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign fwd_port = fwd_q;
  assign hit      = hit_q;

endmodule

// File: tb/tb_lookupflow_learn.sv
// ---------------------------------------------------------------------------
// tb_lookupflow_learn
//   Directed scenarios with literal expectations, then randomized traffic,
//   all compared every cycle against a behavioural table model.
// ---------------------------------------------------------------------------
module tb_lookupflow_learn;

  localparam int NP = 4;
  localparam int DP = 16;
  localparam int AW = 2;
  localparam int AT = 64;
  localparam int AGE_MAX = (1 << AW) - 1;

  localparam logic [47:0] BC      = 48'hffff_ffff_ffff;
  localparam logic [47:0] MC_SRC  = 48'h0100_0000_0055;
  localparam logic [47:0] MC_SRC2 = 48'h0300_0000_0066;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          req = 1'b0;
  logic [95:0]   tuple = '0;
  logic [NP-1:0] in_port = 4'b0001;
  logic          flush = 1'b0;
  logic          ack;
  logic [NP-1:0] fwd_port;
  logic          hit;

  always #5 clk = ~clk;

  lookupflow_learn #(
    .NPORT    (NP),
    .DEPTH    (DP),
    .AGE_W    (AW),
    .AGE_TICK (AT)
  ) dut (
    .sys_clk  (clk),
    .sys_rst  (sys_rst),
    .req      (req),
    .tuple    (tuple),
    .in_port  (in_port),
    .flush    (flush),
    .ack      (ack),
    .fwd_port (fwd_port),
    .hit      (hit)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // ---------------- behavioural model ----------------
  bit          m_v    [DP];
  logic [47:0] m_mac  [DP];
  logic [3:0]  m_port [DP];
  int          m_age  [DP];
  int          m_ptr = 0, m_pre = 0, m_phase = 0;
  logic [47:0] m_dst, m_src;
  logic [3:0]  m_inp;
  int          m_src_idx = -1;
  bit          m_flushed = 0;
  bit          m_known = 0;
  bit          e_ack = 0, e_hit = 0;
  logic [3:0]  e_fwd = '0;
  int          wr_idx, dst_idx;
  bit          tick_now;

  function automatic int find_mac(input logic [47:0] mac);
    for (int i = 0; i < DP; i++)
      if (m_v[i] && m_mac[i] == mac) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (sys_rst) begin
      for (int i = 0; i < DP; i++) begin m_v[i] = 0; m_age[i] = 0; end
      m_ptr = 0; m_pre = 0; m_phase = 0; m_flushed = 0; m_src_idx = -1;
      e_ack = 0; e_hit = 0; e_fwd = '0; m_known = 1;
    end else begin
      tick_now = (m_pre == AT - 1);
      wr_idx = -1;
      // learn target decided on the table as it stands in RESP
      if (m_phase == 2 && !m_src[40] && !m_flushed && !flush) begin
        if (m_src_idx >= 0) wr_idx = m_src_idx;
        else begin
          for (int i = DP - 1; i >= 0; i--) if (!m_v[i]) wr_idx = i;
          if (wr_idx < 0) begin
            wr_idx = m_ptr;
            m_ptr = (m_ptr + 1) % DP;
          end
        end
      end
      e_ack = 0;
      if (m_phase == 1) begin
        dst_idx = find_mac(m_dst);
        e_ack = 1;
        if (m_dst == BC || dst_idx < 0) begin e_fwd = ~m_inp; e_hit = 0; end
        else begin e_fwd = m_port[dst_idx] & ~m_inp; e_hit = 1; end
        m_src_idx = find_mac(m_src);
        m_flushed = flush;
      end
      if (flush) begin
        for (int i = 0; i < DP; i++) m_v[i] = 0;
        m_ptr = 0;
      end else begin
        for (int i = 0; i < DP; i++) begin
          if (i == wr_idx) begin
            m_v[i] = 1; m_mac[i] = m_src; m_port[i] = m_inp; m_age[i] = AGE_MAX;
          end else if (tick_now && m_v[i]) begin
            m_age[i] = m_age[i] - 1;
            if (m_age[i] == 0) m_v[i] = 0;
          end
        end
      end
      m_pre = (m_pre + 1) % AT;
      case (m_phase)
        0: if (req) begin
             m_dst = tuple[95:48]; m_src = tuple[47:0]; m_inp = in_port; m_phase = 1;
           end
        1: m_phase = 2;
        default: m_phase = 0;
      endcase
    end
  end

  // per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (m_known) begin
      n_chk++;
      if (ack === e_ack && fwd_port === e_fwd && hit === e_hit) n_pass++;
      else $display("FAIL cycle_cmp t=%0t got ack=%b hit=%b fwd=%b expected ack=%b hit=%b fwd=%b",
                    $time, ack, hit, fwd_port, e_ack, e_hit, e_fwd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input logic [5:0] exp);
    n_chk++;
    if ({ack, hit, fwd_port} === exp) n_pass++;
    else $display("FAIL %s got {ack,hit,fwd}=%b expected %b", nm, {ack, hit, fwd_port}, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1 req = 1'b0; flush = 1'b0; end
  endtask

  task automatic do_flush();
    @(posedge clk); #1 req = 1'b0; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  // Ends one cycle into RESP, where ack must be high.
  task automatic lookup(input logic [47:0] d, input logic [47:0] s, input logic [3:0] p,
                        input bit fl_m, input bit busy);
    @(posedge clk); #1 req = 1'b1; tuple = {d, s}; in_port = p; flush = 1'b0;
    @(posedge clk); #1 req = busy; tuple = {$urandom(), $urandom(), $urandom()};
    in_port = 4'b0001 << $urandom_range(0, 3); flush = fl_m;
    @(posedge clk); #1 flush = 1'b0;
    $display("lookup dst=%h src=%h in=%b -> ack=%b hit=%b fwd=%b", d, s, p, ack, hit, fwd_port);
  endtask

  logic [47:0] rd, rs;

  initial begin
    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b0;
    chk("reset_state", 6'b0_0_0000);

    lookup(48'h1, 48'h0a, 4'b0001, 0, 0);   chk("miss_flood",     6'b1_0_1110);
    lookup(48'h0a, 48'h0b, 4'b0100, 0, 0);  chk("hit_unicast",    6'b1_1_0001);
    lookup(48'h0b, 48'h0c, 4'b1000, 0, 0);  chk("learned_b",      6'b1_1_0100);
    lookup(48'h0b, 48'h0d, 4'b0100, 0, 0);  chk("hairpin",        6'b1_1_0000);
    lookup(BC, MC_SRC, 4'b1000, 0, 0);      chk("bcast_flood",    6'b1_0_0111);
    lookup(MC_SRC, 48'h0e, 4'b0001, 0, 0);  chk("mc_not_learned", 6'b1_0_1110);

    do_flush();
    lookup(48'h0a, MC_SRC2, 4'b0010, 0, 0); chk("flushed_miss",   6'b1_0_1101);

    // fill every slot, then evict entry 0 and entry 1 in turn
    for (int i = 0; i < DP; i++) lookup(BC, 48'h100 + 48'(i), 4'b0001 << (i % 4), 0, 0);
    lookup(BC, 48'h110, 4'b0001, 0, 0);
    lookup(48'h100, MC_SRC, 4'b0001, 0, 0); chk("evict_e0",       6'b1_0_1110);
    lookup(48'h101, MC_SRC, 4'b0001, 0, 0); chk("keep_e1",        6'b1_1_0010);
    lookup(BC, 48'h111, 4'b0001, 0, 0);
    lookup(48'h101, MC_SRC, 4'b0001, 0, 0); chk("evict_e1",       6'b1_0_1110);

    // aging
    do_flush();
    lookup(BC, 48'h77, 4'b0010, 0, 0);
    idle(200);
    lookup(48'h77, MC_SRC, 4'b0001, 0, 0);  chk("aged_out",       6'b1_0_1110);
    lookup(BC, 48'h78, 4'b0010, 0, 0);
    idle(100);
    lookup(BC, 48'h78, 4'b0010, 0, 0);
    idle(100);
    lookup(48'h78, MC_SRC, 4'b0001, 0, 0);  chk("refreshed",      6'b1_1_0010);

    // flush during MATCH, with req held high while busy
    lookup(BC, 48'h90, 4'b0001, 0, 0);
    lookup(48'h90, 48'h91, 4'b0100, 1, 1);  chk("flush_in_match", 6'b1_1_0001);
    idle(1);
    lookup(48'h90, MC_SRC, 4'b0010, 0, 0);  chk("flush_cleared",  6'b1_0_1101);
    lookup(48'h91, MC_SRC, 4'b0010, 0, 0);  chk("no_learn_flush", 6'b1_0_1101);

    // reset while in MATCH: the response never comes
    @(posedge clk); #1 req = 1'b1; tuple = {48'h90, 48'h99}; in_port = 4'b0001;
    @(posedge clk); #1 req = 1'b0; sys_rst = 1'b1;
    @(posedge clk); #1 sys_rst = 1'b0;
    chk("rst_in_match_noack", 6'b0_0_0000);
    idle(3);

    // randomized traffic over a small MAC pool
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      sys_rst = ($urandom_range(0, 999) == 0);
      req     = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 59) == 0);
      rd = {16'h00aa, 32'($urandom_range(0, 23))};
      if ($urandom_range(0, 9) == 0) rd = BC;
      rs = {16'h00aa, 32'($urandom_range(0, 23))};
      if ($urandom_range(0, 7) == 0) rs[40] = 1'b1;
      tuple   = {rd, rs};
      in_port = 4'b0001 << $urandom_range(0, 3);
      if (e_ack) $display("rand t=%0t ack=%b hit=%b fwd=%b", $time, ack, hit, fwd_port);
    end
    #1 sys_rst = 1'b0;
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
